// File: rtl/pipeline_stall_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, mult/div and
// branch-redirect hazards into latch enables, bubbles and the mult/div handshake.
module pipeline_stall_sequencer #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             lw_hazard,
  input  logic             dx_is_md,
  input  logic             md_ready,
  input  logic             br_taken,
  output logic             pc_en,
  output logic             fd_en,
  output logic             fd_flush,
  output logic             dx_en,
  output logic             dx_bubble,
  output logic             xm_bubble,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic ST_RUN     = 1'b0;
  localparam logic ST_MD_WAIT = 1'b1;

  localparam int              WC_W    = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MD_TIMEOUT - 1);

  logic             r_state;
  logic [WC_W-1:0]  r_wait_cnt;
  logic             r_md_timeout;
  logic [CNT_W-1:0] r_stall_count;

  logic w_in_run;
  logic w_in_wait;
  logic w_timeout_hit;
  logic w_stall_md;
  logic w_flush;
  logic w_stall_lw;
  logic w_pc_en;

  // Priority: mult/div occupancy > branch flush > load-use stall.
  always_comb begin
    w_in_run      = (r_state == ST_RUN);
    w_in_wait     = (r_state == ST_MD_WAIT);
    w_timeout_hit = w_in_wait & (r_wait_cnt == WC_LAST);
    w_stall_md    = (w_in_run & dx_is_md) | (w_in_wait & ~md_ready & ~w_timeout_hit);
    w_flush       = br_taken & ~w_stall_md;
    w_stall_lw    = lw_hazard & ~w_stall_md & ~br_taken;
    w_pc_en       = ~(w_stall_md | w_stall_lw);
  end

  assign pc_en       = w_pc_en;
  assign fd_en       = w_pc_en;
  assign dx_en       = ~w_stall_md;
  assign dx_bubble   = w_stall_lw | w_flush;
  assign fd_flush    = w_flush;
  assign xm_bubble   = w_stall_md;
  // Gated by reset so no start pulse escapes while the unit is held in reset.
  assign md_start    = w_in_run & dx_is_md & reset;
  assign md_busy     = w_in_wait;
  assign md_timeout  = r_md_timeout;
  assign stall_count = r_stall_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (dx_is_md) begin
            r_state    <= ST_MD_WAIT;
            r_wait_cnt <= '0;
          end
        end
        default: begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
          if (md_ready || w_timeout_hit) begin
            r_state <= ST_RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_md_timeout <= 1'b0;
    end else if (w_timeout_hit) begin
      r_md_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_count <= '0;
    end else if (!w_pc_en && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Directed bench for pipeline_stall_sequencer; a second instance with a 4-bit
// counter shares the stimulus to exercise stall_count saturation.
module tb_pipeline_stall_sequencer;

  logic clock;
  logic reset;
  logic lw_hazard;
  logic dx_is_md;
  logic md_ready;
  logic br_taken;

  logic        pc_en, fd_en, fd_flush, dx_en, dx_bubble, xm_bubble;
  logic        md_start, md_busy, md_timeout;
  logic [15:0] stall_count;

  logic        s_pc_en, s_fd_en, s_fd_flush, s_dx_en, s_dx_bubble, s_xm_bubble;
  logic        s_md_start, s_md_busy, s_md_timeout;
  logic [3:0]  s_stall_count;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  pipeline_stall_sequencer #(.MD_TIMEOUT(40), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .lw_hazard(lw_hazard), .dx_is_md(dx_is_md),
    .md_ready(md_ready), .br_taken(br_taken), .pc_en(pc_en), .fd_en(fd_en),
    .fd_flush(fd_flush), .dx_en(dx_en), .dx_bubble(dx_bubble), .xm_bubble(xm_bubble),
    .md_start(md_start), .md_busy(md_busy), .md_timeout(md_timeout),
    .stall_count(stall_count)
  );

  pipeline_stall_sequencer #(.MD_TIMEOUT(40), .CNT_W(4)) dut_sat (
    .clock(clock), .reset(reset), .lw_hazard(lw_hazard), .dx_is_md(dx_is_md),
    .md_ready(md_ready), .br_taken(br_taken), .pc_en(s_pc_en), .fd_en(s_fd_en),
    .fd_flush(s_fd_flush), .dx_en(s_dx_en), .dx_bubble(s_dx_bubble), .xm_bubble(s_xm_bubble),
    .md_start(s_md_start), .md_busy(s_md_busy), .md_timeout(s_md_timeout),
    .stall_count(s_stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Apply inputs for the current cycle and let the combinational outputs settle.
  task automatic drive(input logic lw, input logic md, input logic rdy, input logic br);
    lw_hazard = lw;
    dx_is_md  = md;
    md_ready  = rdy;
    br_taken  = br;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state
    chk("rst_pc_en", pc_en, 1);
    chk("rst_fd_en", fd_en, 1);
    chk("rst_dx_en", dx_en, 1);
    chk("rst_fd_flush", fd_flush, 0);
    chk("rst_dx_bubble", dx_bubble, 0);
    chk("rst_xm_bubble", xm_bubble, 0);
    chk("rst_md_busy", md_busy, 0);
    chk("rst_md_timeout", md_timeout, 0);
    chk("rst_stall_count", stall_count, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_md_start_forced0", md_start, 0);
    tick();
    chk("rst_hold_md_busy", md_busy, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    // Load-use stall for one cycle
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("lw_pc_en", pc_en, 0);
    chk("lw_fd_en", fd_en, 0);
    chk("lw_dx_en", dx_en, 1);
    chk("lw_dx_bubble", dx_bubble, 1);
    chk("lw_fd_flush", fd_flush, 0);
    chk("lw_xm_bubble", xm_bubble, 0);
    chk("lw_cnt_before", stall_count, 0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("lw_cnt_after", stall_count, 1);
    chk("lw_pc_en_release", pc_en, 1);

    // Branch taken overrides load-use
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    chk("br_pc_en", pc_en, 1);
    chk("br_fd_en", fd_en, 1);
    chk("br_fd_flush", fd_flush, 1);
    chk("br_dx_bubble", dx_bubble, 1);
    chk("br_dx_en", dx_en, 1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("br_cnt_unchanged", stall_count, 1);

    // md_ready in RUN without a mult/div is ignored
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("rdy_run_pc_en", pc_en, 1);
    chk("rdy_run_xm_bubble", xm_bubble, 0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rdy_run_md_busy", md_busy, 0);
    chk("rdy_run_cnt", stall_count, 1);

    // Mult/div with md_ready at T0+33
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("md_t0_start", md_start, 1);
    chk("md_t0_busy", md_busy, 0);
    chk("md_t0_pc_en", pc_en, 0);
    chk("md_t0_dx_en", dx_en, 0);
    chk("md_t0_xm_bubble", xm_bubble, 1);
    chk("md_t0_dx_bubble", dx_bubble, 0);
    for (int k = 1; k <= 32; k++) begin
      tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      chk("md_wait_start", md_start, 0);
      chk("md_wait_busy", md_busy, 1);
      chk("md_wait_pc_en", pc_en, 0);
    end
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    chk("md_rdy_pc_en", pc_en, 1);
    chk("md_rdy_fd_en", fd_en, 1);
    chk("md_rdy_dx_en", dx_en, 1);
    chk("md_rdy_xm_bubble", xm_bubble, 0);
    chk("md_rdy_busy", md_busy, 1);
    chk("md_rdy_start", md_start, 0);
    chk("md_rdy_cnt", stall_count, 34);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("md_done_busy", md_busy, 0);
    chk("md_done_timeout", md_timeout, 0);
    chk("md_done_cnt", stall_count, 34);

    // Mult/div timeout with no md_ready
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("to_t0_start", md_start, 1);
    for (int k = 1; k <= 39; k++) begin
      tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      chk("to_wait_busy", md_busy, 1);
      chk("to_wait_pc_en", pc_en, 0);
    end
    chk("to_pre_timeout", md_timeout, 0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("to_term_pc_en", pc_en, 1);
    chk("to_term_xm_bubble", xm_bubble, 0);
    chk("to_term_busy", md_busy, 1);
    chk("to_term_timeout", md_timeout, 0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("to_after_busy", md_busy, 0);
    chk("to_after_timeout", md_timeout, 1);
    chk("to_after_cnt", stall_count, 74);
    tick();
    tick();
    chk("to_sticky", md_timeout, 1);

    // Reset in the middle of MD_WAIT
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("mrst_busy_before", md_busy, 1);
    reset = 1'b0;
    #1;
    chk("mrst_busy", md_busy, 0);
    chk("mrst_cnt", stall_count, 0);
    chk("mrst_timeout", md_timeout, 0);
    chk("mrst_start", md_start, 0);
    tick();
    chk("mrst_start_held", md_start, 0);
    chk("mrst_cnt_held", stall_count, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("mrst_restart", md_start, 1);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    chk("mrst_restart_busy", md_busy, 1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("mrst_restart_cnt", stall_count, 1);
    chk("sat_start_cnt", s_stall_count, 1);

    // Saturation: 20 lw stall cycles on a 4-bit counter
    for (int k = 1; k <= 20; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      if (k == 14) chk("sat_cnt_15", s_stall_count, 15);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_cnt_hold", s_stall_count, 15);
    chk("wide_cnt_21", stall_count, 21);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
